// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the staged reset sequencer.
package rst_seq_pkg;
  localparam int FS_W       = 4;
  localparam int MAX_STAGES = 16;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DELAY    = 3'd1,
    S_WAIT_ACK = 3'd2,
    S_RUN      = 3'd3,
    S_FAULT    = 3'd4
  } state_e;
endpackage

// File: rtl/rst_seq_if.sv
// Control/status bundle between the reset sequencer and its environment.
interface rst_seq_if #(
  parameter int NUM_STAGES = 4
);
  import rst_seq_pkg::*;

  logic                  pwr_ok;
  logic                  soft_rst_req;
  logic [NUM_STAGES-1:0] stage_ack;
  logic [NUM_STAGES-1:0] stage_rst_n;
  logic                  all_ready;
  logic                  fault;
  logic [FS_W-1:0]       fault_stage;

  modport master (
    input  pwr_ok, soft_rst_req, stage_ack,
    output stage_rst_n, all_ready, fault, fault_stage
  );

  modport slave (
    output pwr_ok, soft_rst_req, stage_ack,
    input  stage_rst_n, all_ready, fault, fault_stage
  );
endinterface

// File: rtl/rst_seq_timer.sv
// Shared delay/timeout counter; hit_o is registered and equals (count == term_i).
module seq_timer #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic [CNT_W-1:0] term_i,
  output logic             hit_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hit_q, hit_d;

  // Saturate rather than wrap so a stale count can never re-hit.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)             cnt_d = '0;
    else if (cnt_q != '1)  cnt_d = cnt_q + 1'b1;
    hit_d = (cnt_d == term_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      hit_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      hit_q <= hit_d;
    end
  end

  assign hit_o = hit_q;
endmodule

// File: rtl/rst_seq.sv
// Staged reset sequencer: releases NUM_STAGES reset domains in order,
// waiting a fixed delay before each release and an ack after it.
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int NUM_STAGES  = 4,
  parameter int STAGE_DELAY = 1000,
  parameter int ACK_TIMEOUT = 100000,
  parameter int CNT_W       = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  rst_seq_if.master bus
);
  localparam logic [FS_W-1:0]  IDX_LAST  = FS_W'(NUM_STAGES - 1);
  localparam logic [CNT_W-1:0] TERM_DLY  = CNT_W'(STAGE_DELAY);
  localparam logic [CNT_W-1:0] TERM_TOUT = CNT_W'(ACK_TIMEOUT - 1);

  state_e                state_q, state_d;
  logic [FS_W-1:0]       idx_q, idx_d;
  logic [NUM_STAGES-1:0] srst_q, srst_d;
  logic                  rdy_q, rdy_d;
  logic                  flt_q, flt_d;
  logic [FS_W-1:0]       fs_q, fs_d;

  logic                  hit;
  logic                  tmr_clr;
  logic [CNT_W-1:0]      tmr_term;
  logic                  ack_cur;
  logic                  any_drop;
  logic [FS_W-1:0]       low_drop;

  // Ack of the stage currently being waited on, and lowest lost ack in RUN.
  always_comb begin
    ack_cur  = 1'b0;
    low_drop = '0;
    for (int i = 0; i < NUM_STAGES; i++)
      if (idx_q == FS_W'(i)) ack_cur = bus.stage_ack[i];
    for (int j = NUM_STAGES - 1; j >= 0; j--)
      if (!bus.stage_ack[j]) low_drop = FS_W'(j);
    any_drop = ~&bus.stage_ack;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      srst_q  <= '0;
      rdy_q   <= 1'b0;
      flt_q   <= 1'b0;
      fs_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      srst_q  <= srst_d;
      rdy_q   <= rdy_d;
      flt_q   <= flt_d;
      fs_q    <= fs_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!bus.pwr_ok)
      state_d = S_IDLE;
    else if (bus.soft_rst_req && state_q != S_IDLE)
      state_d = S_IDLE;
    else begin
      unique case (state_q)
        S_IDLE:     state_d = S_DELAY;
        S_DELAY:    if (hit) state_d = S_WAIT_ACK;
        S_WAIT_ACK: begin
          if (ack_cur)  state_d = (idx_q == IDX_LAST) ? S_RUN : S_DELAY;
          else if (hit) state_d = S_FAULT;
        end
        S_RUN:      if (any_drop) state_d = S_FAULT;
        S_FAULT:    state_d = S_FAULT;
        default:    state_d = S_IDLE;
      endcase
    end
  end

  // Every state entry restarts the shared counter against the new state's terminal.
  assign tmr_clr  = (state_d != state_q);
  assign tmr_term = (state_d == S_DELAY) ? TERM_DLY : TERM_TOUT;

  always_comb begin
    idx_d  = idx_q;
    srst_d = srst_q;
    fs_d   = fs_q;
    flt_d  = (state_d == S_FAULT);
    rdy_d  = (state_q == S_RUN) && (state_d == S_RUN);
    if (state_d == S_IDLE) begin
      idx_d  = '0;
      srst_d = '0;
    end else begin
      if (state_q == S_WAIT_ACK && state_d == S_DELAY)
        idx_d = idx_q + 1'b1;
      if (state_q == S_DELAY && state_d == S_WAIT_ACK)
        for (int i = 0; i < NUM_STAGES; i++)
          if (idx_q == FS_W'(i)) srst_d[i] = 1'b1;
      if (state_q == S_WAIT_ACK && state_d == S_FAULT) fs_d = idx_q;
      if (state_q == S_RUN && state_d == S_FAULT)      fs_d = low_drop;
    end
  end

  seq_timer #(.CNT_W(CNT_W)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (tmr_clr),
    .term_i (tmr_term),
    .hit_o  (hit)
  );

  assign bus.stage_rst_n = srst_q;
  assign bus.all_ready   = rdy_q;
  assign bus.fault       = flt_q;
  assign bus.fault_stage = fs_q;
endmodule

// File: tb/tb_rst_seq.sv
// Scoreboarded bench for rst_seq: expected output changes are queued by the
// stimulus with their edge number; the monitor matches every observed change.
module tb_rst_seq;
  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   fails;

  typedef struct {
    int         cyc;
    logic [9:0] key;
  } ev_t;

  ev_t sb[$];

  rst_seq_if #(.NUM_STAGES(4)) bus();

  rst_seq #(
    .NUM_STAGES  (4),
    .STAGE_DELAY (10),
    .ACK_TIMEOUT (50),
    .CNT_W       (32)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [9:0] mk(logic [3:0] r, logic a, logic f, logic [3:0] s);
    return {r, a, f, (f ? s : 4'd0)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic at(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ev(input int c, input logic [3:0] r, input logic a, input logic f,
                    input logic [3:0] s);
    ev_t e;
    e.cyc = c;
    e.key = mk(r, a, f, s);
    sb.push_back(e);
  endtask

  initial begin
    logic [9:0] prev, cur;
    ev_t        e;
    cyc = 0; checks = 0; fails = 0;
    rst_n = 1'b0;
    bus.pwr_ok = 1'b0;
    bus.soft_rst_req = 1'b0;
    bus.stage_ack = 4'b0000;
    prev = '0;
    fork
      begin
        #1;
        chk("reset_stage_rst_n", 32'(bus.stage_rst_n), 32'd0);
        chk("reset_all_ready",   32'(bus.all_ready),   32'd0);
        chk("reset_fault",       32'(bus.fault),       32'd0);
        chk("reset_fault_stage", 32'(bus.fault_stage), 32'd0);
        at(2);  rst_n = 1'b1;
        // nominal sequence, acks 3 cycles after each release
        ev(16, 4'b0001, 0, 0, 0); ev(30, 4'b0011, 0, 0, 0);
        ev(44, 4'b0111, 0, 0, 0); ev(58, 4'b1111, 0, 0, 0);
        ev(62, 4'b1111, 1, 0, 0);
        at(4);  bus.pwr_ok = 1'b1;
        at(18); bus.stage_ack = 4'b0001;
        at(32); bus.stage_ack = 4'b0011;
        at(46); bus.stage_ack = 4'b0111;
        at(60); bus.stage_ack = 4'b1111;
        // run-time loss of two acks at once
        ev(71, 4'b1111, 0, 1, 1);
        at(70); bus.stage_ack = 4'b0101;
        // soft re-sequence from FAULT, then stage 2 times out
        ev(81, 4'b0000, 0, 0, 0); ev(93, 4'b0001, 0, 0, 0);
        ev(105, 4'b0011, 0, 0, 0); ev(118, 4'b0111, 0, 0, 0);
        ev(168, 4'b0111, 0, 1, 2);
        at(80);  bus.soft_rst_req = 1'b1; bus.stage_ack = 4'b0000;
        at(81);  bus.soft_rst_req = 1'b0;
        at(85);  bus.stage_ack = 4'b0001;
        at(106); bus.stage_ack = 4'b0011;
        // soft from FAULT, full sequence to RUN
        ev(176, 4'b0000, 0, 0, 0); ev(188, 4'b0001, 0, 0, 0);
        ev(202, 4'b0011, 0, 0, 0); ev(216, 4'b0111, 0, 0, 0);
        ev(230, 4'b1111, 0, 0, 0); ev(234, 4'b1111, 1, 0, 0);
        at(175); bus.soft_rst_req = 1'b1; bus.stage_ack = 4'b0000;
        at(176); bus.soft_rst_req = 1'b0;
        at(190); bus.stage_ack = 4'b0001;
        at(204); bus.stage_ack = 4'b0011;
        at(218); bus.stage_ack = 4'b0111;
        at(232); bus.stage_ack = 4'b1111;
        // soft from RUN, then power loss in WAIT_ACK of stage 1
        ev(241, 4'b0000, 0, 0, 0); ev(253, 4'b0001, 0, 0, 0);
        ev(267, 4'b0011, 0, 0, 0); ev(271, 4'b0000, 0, 0, 0);
        at(240); bus.soft_rst_req = 1'b1; bus.stage_ack = 4'b0000;
        at(241); bus.soft_rst_req = 1'b0;
        at(255); bus.stage_ack = 4'b0001;
        at(270); bus.pwr_ok = 1'b0;
        at(275); bus.soft_rst_req = 1'b1;
        at(276); bus.soft_rst_req = 1'b0;
        at(280); bus.soft_rst_req = 1'b1;
        at(281); bus.soft_rst_req = 1'b0;
        // power back with every ack already high: one cycle per WAIT_ACK
        ev(297, 4'b0001, 0, 0, 0); ev(309, 4'b0011, 0, 0, 0);
        ev(321, 4'b0111, 0, 0, 0); ev(333, 4'b1111, 0, 0, 0);
        ev(335, 4'b1111, 1, 0, 0);
        at(283); bus.stage_ack = 4'b1111;
        at(285); bus.pwr_ok = 1'b1;
        // asynchronous reset in RUN, between edges
        ev(340, 4'b0000, 0, 0, 0);
        at(340); #2;
        rst_n = 1'b0;
        #1;
        chk("async_stage_rst_n", 32'(bus.stage_rst_n), 32'd0);
        chk("async_all_ready",   32'(bus.all_ready),   32'd0);
        chk("async_fault",       32'(bus.fault),       32'd0);
        at(350);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      end
      forever begin
        @(negedge clk);
        cur = mk(bus.stage_rst_n, bus.all_ready, bus.fault, bus.fault_stage);
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
          checks++;
          fails++;
          $display("FAIL missed_event edge=%0d act=%h exp=%h", sb[0].cyc, cur, sb[0].key);
          void'(sb.pop_front());
        end
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
          e = sb.pop_front();
          chk($sformatf("event_edge%0d", cyc), 32'(cur), 32'(e.key));
        end else if (cur != prev) begin
          checks++;
          fails++;
          $display("FAIL unexpected_change edge=%0d act=%h exp=%h", cyc, cur, prev);
        end
        prev = cur;
      end
    join_any
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
